// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the program-counter generator.
// Used by pc_gen and, when PC_GEN_RAS_EN is defined, by pc_gen_ras.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  // Widest address supported; operands are widened to this and truncated by the caller.
  localparam int PC_MAX_AW = 64;
  localparam int unsigned ALIGN_BITS_DEFAULT = 2;

  typedef logic [PC_MAX_AW-1:0] pc_addr_t;

  typedef struct packed {
    pc_addr_t target;
    logic     misalign;
  } redir_res_t;

  function automatic int unsigned align_bits_of(input int unsigned inst_bytes);
    return (inst_bytes == 2) ? 1 : 2;
  endfunction

  // JALR clears bit 0 before the alignment check, as the ISA requires.
  function automatic redir_res_t calc_redirect(
    input logic        jalr,
    input pc_addr_t    pc,
    input pc_addr_t    rs1,
    input pc_addr_t    imm,
    input int unsigned align_bits
  );
    redir_res_t res;
    pc_addr_t   mask;
    mask = (pc_addr_t'(1) << align_bits) - pc_addr_t'(1);
    if (jalr) begin
      res.target = (rs1 + imm) & ~pc_addr_t'(1);
    end else begin
      res.target = pc + imm;
    end
    res.misalign = |(res.target & mask);
    return res;
  endfunction

endpackage

// File: rtl/pc_gen_ras.sv
// Circular return-address stack for pc_gen; a full push drops the oldest entry.
// Only instantiated when PC_GEN_RAS_EN is defined.
module pc_gen_ras
  import pc_gen_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] top_ptr;
  logic [PW-1:0] wr_ptr_inc;
  logic [CW-1:0] count;
  logic          is_empty;
  logic          replace_top;

  assign is_empty    = (count == '0);
  assign replace_top = push && pop && !is_empty;
  assign top_ptr     = (wr_ptr == '0) ? PW'(DEPTH - 1) : wr_ptr - PW'(1);
  assign wr_ptr_inc  = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
  assign top         = is_empty ? '0 : mem[top_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (replace_top) begin
      count <= count;
    end else if (push) begin
      wr_ptr <= wr_ptr_inc;
      if (count != CW'(DEPTH)) begin
        count <= count + CW'(1);
      end
    end else if (pop && !is_empty) begin
      wr_ptr <= top_ptr;
      count  <= count - CW'(1);
    end
  end

  // Storage carries no reset; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (replace_top) begin
        mem[top_ptr] <= push_data;
      end else if (push) begin
        mem[wr_ptr] <= push_data;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: boot/run/halt control, fetch handshake and execute redirects.
// Define PC_GEN_RAS_EN to add the return-address stack (pc_gen_ras) and the ras_* ports.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0,
  parameter logic [ADDRESS_WIDTH-1:0] TRAP_VECTOR   = ADDRESS_WIDTH'(32'h0000_0100),
  parameter int                       INST_BYTES    = 1 << ALIGN_BITS_DEFAULT
`ifdef PC_GEN_RAS_EN
  , parameter int                     RAS_DEPTH     = 4
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pc_ready,
  output logic                     pc_valid,
  output logic [ADDRESS_WIDTH-1:0] PC,
  input  logic                     redir_valid,
  input  logic                     redir_jalr,
  input  logic [ADDRESS_WIDTH-1:0] redir_pc,
  input  logic [ADDRESS_WIDTH-1:0] redir_rs1,
  input  logic [ADDRESS_WIDTH-1:0] ImmOp,
  output logic [ADDRESS_WIDTH-1:0] link_addr,
  input  logic                     halt,
  input  logic                     resume,
  output logic                     misalign_err,
  output logic [ADDRESS_WIDTH-1:0] bad_addr
`ifdef PC_GEN_RAS_EN
  , input  logic                     ras_push
  , input  logic                     ras_pop
  , output logic [ADDRESS_WIDTH-1:0] ras_top
`endif
);

  localparam int unsigned             ALIGN_BITS = align_bits_of(INST_BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] STEP      = ADDRESS_WIDTH'(INST_BYTES);

  pc_state_e                state;
  redir_res_t               redir_calc;
  logic [ADDRESS_WIDTH-1:0] redir_target;
  logic [ADDRESS_WIDTH-1:0] link_next;
  logic                     redir_accept;
  logic                     unused_calc;

  assign redir_calc   = calc_redirect(redir_jalr, pc_addr_t'(redir_pc), pc_addr_t'(redir_rs1),
                                      pc_addr_t'(ImmOp), ALIGN_BITS);
  assign redir_target = redir_calc.target[ADDRESS_WIDTH-1:0];
  assign link_next    = redir_pc + STEP;
  assign redir_accept = redir_valid && (state != BOOT);
  assign unused_calc  = ^redir_calc.target;

  // Redirects win over stall, increment and halt; a halted core takes the new PC but stays halted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BOOT;
      PC           <= RESET_VECTOR;
      pc_valid     <= 1'b0;
      link_addr    <= '0;
      misalign_err <= 1'b0;
      bad_addr     <= '0;
    end else begin
      misalign_err <= 1'b0;
      if (redir_accept) begin
        if (redir_calc.misalign) begin
          PC           <= TRAP_VECTOR;
          misalign_err <= 1'b1;
          bad_addr     <= redir_target;
        end else begin
          PC        <= redir_target;
          link_addr <= link_next;
        end
      end
      unique case (state)
        BOOT: begin
          state    <= RUN;
          pc_valid <= 1'b1;
        end
        RUN: begin
          if (!redir_valid) begin
            if (pc_ready) begin
              PC <= PC + STEP;
            end
            if (halt) begin
              state    <= HALT;
              pc_valid <= 1'b0;
            end
          end
        end
        HALT: begin
          if (resume && !halt) begin
            state    <= RUN;
            pc_valid <= 1'b1;
          end
        end
        default: begin
          state    <= BOOT;
          pc_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_GEN_RAS_EN
  // Only a redirect that actually updates link_addr may push its return address.
  pc_gen_ras #(
    .DEPTH(RAS_DEPTH),
    .AW   (ADDRESS_WIDTH)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (ras_push && redir_accept && !redir_calc.misalign),
    .pop      (ras_pop),
    .push_data(link_next),
    .top      (ras_top)
  );
`endif

endmodule
